seq_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit for the CPU datapath, next generation of the single-cycle ALU. The combinational ALU keeps add/logic/shift/compare; this block takes MUL, MULH and DIV/REM (unsigned and signed) off the critical path with a radix-2 shift-add / restoring-divide engine. It uses a valid/ready handshake on both sides, so the pipeline stalls on it like a memory access.

---
 rtl/seq_muldiv.sv | 137 +++++++++++++
 tb/tb_seq_muldiv.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_muldiv.sv
// Iterative radix-2 multiply / divide unit with valid/ready handshake on both sides.
// One result bit per cycle: shift-add for MUL*, restoring division for DIV*/REM*.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | WIDTH iterations on operand magnitudes
// DONE  | result held on out until consumer takes it
module seq_muldiv #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             div_zero,
   input  logic             flush
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t state, state_nx;

   logic [2:0]         op_q;
   logic               neg_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [WIDTH:0]     rem_q;
   logic [CW-1:0]      cnt_q;

   logic             start, is_mul, is_signed, b_zero, fast, sign_in;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);

   assign start     = in_valid && in_ready && !flush;
   assign is_mul    = (op <= 3'd2);
   assign is_signed = (op == 3'd2) || (op == 3'd5) || (op == 3'd6);
   assign b_zero    = (b == '0);
   assign fast      = (op == 3'd7) || (!is_mul && b_zero);
   assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
   assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;
   // remainder takes the dividend's sign, everything else the product of signs
   assign sign_in   = is_signed && ((op == 3'd6) ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]));

   // one iteration step
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_nx, div_nx, acc_nx, prod_neg;
   logic [WIDTH:0]     div_shift, rem_nx;
   logic [WIDTH+1:0]   div_diff;
   logic [WIDTH-1:0]   quo, rem_mag, result;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
      mul_nx    = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
      div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
      div_nx    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
      rem_nx    = div_diff[WIDTH+1] ? div_shift : div_diff[WIDTH:0];
      acc_nx    = (op_q <= 3'd2) ? mul_nx : div_nx;
      prod_neg  = neg_q ? -acc_nx : acc_nx;
      quo       = neg_q ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
      rem_mag   = neg_q ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
      result    = '0;
      case (op_q)
         3'd0:       result = acc_nx[WIDTH-1:0];
         3'd1:       result = acc_nx[2*WIDTH-1:WIDTH];
         3'd2:       result = prod_neg[2*WIDTH-1:WIDTH];
         3'd3, 3'd5: result = quo;
         3'd4, 3'd6: result = rem_mag;
         default:    result = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (start) state_nx = fast ? S_DONE : S_RUN;
         S_RUN:  if (cnt_q == CW'(1)) state_nx = S_DONE;
         S_DONE: if (out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (flush) state_nx = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         out      <= '0;
         div_zero <= 1'b0;
      end else if (start) begin
         op_q     <= op;
         neg_q    <= sign_in;
         cnt_q    <= CW'(WIDTH);
         rem_q    <= '0;
         div_zero <= fast && (op != 3'd7);
         // multiplier / dividend sits in the low half and shifts out one bit per cycle
         if (is_mul) begin
            opnd_q <= a_mag;
            acc_q  <= {{WIDTH{1'b0}}, b_mag};
         end else begin
            opnd_q <= b_mag;
            acc_q  <= {{WIDTH{1'b0}}, a_mag};
         end
         if (op == 3'd7)                     out <= '0;
         else if (fast)                      out <= ((op == 3'd3) || (op == 3'd5)) ? '1 : a;
      end else if ((state == S_RUN) && !flush) begin
         acc_q <= acc_nx;
         rem_q <= rem_nx;
         cnt_q <= cnt_q - CW'(1);
         if (cnt_q == CW'(1)) out <= result;
      end
   end

endmodule

// File: tb/tb_seq_muldiv.sv
// Bench for seq_muldiv: three widths (8/16/32) against a plain-arithmetic reference,
// directed literal cases at WIDTH 16, handshake, flush and reset behaviour.
module tb_seq_muldiv;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]       iv = '0, ordy = '0, fl = '0;
   logic [2:0][2:0]  opv = '0;
   logic [2:0][31:0] av = '0, bv = '0;

   logic        r8, r16, r32, v8, v16, v32, d8, d16, d32;
   logic [7:0]  o8;
   logic [15:0] o16;
   logic [31:0] o32;

   logic [2:0]       irdy, ovld, dzv;
   logic [2:0][31:0] outv;
   assign irdy = {r32, r16, r8};
   assign ovld = {v32, v16, v8};
   assign dzv  = {d32, d16, d8};
   assign outv = {o32, {16'h0, o16}, {24'h0, o8}};

   seq_muldiv #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(r8), .op(opv[0]),
      .a(av[0][7:0]), .b(bv[0][7:0]), .out_valid(v8), .out_ready(ordy[0]),
      .out(o8), .div_zero(d8), .flush(fl[0]));
   seq_muldiv #(.WIDTH(16)) u_w16 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(r16), .op(opv[1]),
      .a(av[1][15:0]), .b(bv[1][15:0]), .out_valid(v16), .out_ready(ordy[1]),
      .out(o16), .div_zero(d16), .flush(fl[1]));
   seq_muldiv #(.WIDTH(32)) u_w32 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(r32), .op(opv[2]),
      .a(av[2]), .b(bv[2]), .out_valid(v32), .out_ready(ordy[2]),
      .out(o32), .div_zero(d32), .flush(fl[2]));

   int total = 0;
   int bad = 0;

   logic [2:0]       pend = '0;
   logic [2:0]       exp_dz = '0;
   logic [2:0][31:0] exp_out = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int wof(input int k);
      return (k == 0) ? 8 : (k == 1) ? 16 : 32;
   endfunction

   // reference: signed/unsigned integer arithmetic on 64-bit values, masked to width
   task automatic model(input int w, input logic [2:0] o, input logic [31:0] x, y,
                        output logic [31:0] r, output logic dz);
      longint unsigned m, ux, uy;
      longint sx, sy;
      m  = (64'd1 << w) - 64'd1;
      ux = {32'h0, x} & m;
      uy = {32'h0, y} & m;
      sx = x[w-1] ? longint'(ux) - longint'(64'd1 << w) : longint'(ux);
      sy = y[w-1] ? longint'(uy) - longint'(64'd1 << w) : longint'(uy);
      dz = 1'b0;
      r  = '0;
      case (o)
         3'd0: r = 32'((ux * uy) & m);
         3'd1: r = 32'(((ux * uy) >> w) & m);
         3'd2: r = 32'(longint'(unsigned'((sx * sy) >>> w)) & m);
         3'd3: if (uy == 0) begin dz = 1'b1; r = 32'(m); end else r = 32'(ux / uy);
         3'd4: if (uy == 0) begin dz = 1'b1; r = 32'(ux); end else r = 32'(ux % uy);
         3'd5: if (uy == 0) begin dz = 1'b1; r = 32'(m); end
               else r = 32'(longint'(unsigned'(sx / sy)) & m);
         3'd6: if (uy == 0) begin dz = 1'b1; r = 32'(ux); end
               else r = 32'(longint'(unsigned'(sx % sy)) & m);
         default: r = '0;
      endcase
   endtask

   // compare process: every cycle a result is presented it must match the model
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 3; k++) begin
            if (ovld[k]) begin
               if (!pend[k]) chk("unexpected_valid", ovld[k], 1'b0);
               else begin
                  chk("out", outv[k], exp_out[k]);
                  chk("div_zero", dzv[k], exp_dz[k]);
                  chk("in_ready_in_done", irdy[k], 1'b0);
               end
            end
         end
      end
   end

   task automatic run_op(input int k, input logic [2:0] o, input logic [31:0] x, y,
                         input int hold, output logic [31:0] got, output logic got_dz);
      int w, lat, n;
      logic [31:0] e, mk;
      logic ed, fast;
      w  = wof(k);
      mk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      model(w, o, x, y, e, ed);
      fast = (o == 3'd7) || ((o >= 3'd3) && (o <= 3'd6) && ((y & mk) == 0));
      got = '0;
      got_dz = 1'b0;
      n = 0;
      while (!irdy[k] && n < 100) begin @(negedge clk); n++; end
      if (!irdy[k]) begin chk("ready_timeout", irdy[k], 1'b1); return; end
      exp_out[k] = e;
      exp_dz[k]  = ed;
      pend[k]    = 1'b1;
      iv[k] = 1'b1; opv[k] = o; av[k] = x; bv[k] = y;
      @(negedge clk);
      iv[k] = 1'b0; opv[k] = 3'($urandom); av[k] = $urandom; bv[k] = $urandom;
      lat = 1;
      while (!ovld[k] && lat < 80) begin
         chk("in_ready_busy", irdy[k], 1'b0);
         ordy[k] = 1'($urandom);
         @(negedge clk);
         lat++;
      end
      ordy[k] = 1'b0;
      chk("latency", lat, fast ? 1 : w + 1);
      if (!ovld[k]) begin pend[k] = 1'b0; return; end
      got = outv[k];
      got_dz = dzv[k];
      repeat (hold) @(negedge clk);
      ordy[k] = 1'b1;
      @(negedge clk);
      ordy[k] = 1'b0;
      pend[k] = 1'b0;
      chk("in_ready_after_handoff", irdy[k], 1'b1);
      chk("valid_after_handoff", ovld[k], 1'b0);
   endtask

   task automatic lit(input string nm, input logic [2:0] o, input logic [31:0] x, y,
                      input logic [31:0] er, input logic edz);
      logic [31:0] g;
      logic gd;
      run_op(1, o, x, y, 0, g, gd);
      chk(nm, g, er);
      chk({nm, "_dz"}, gd, edz);
   endtask

   initial begin
      logic [31:0] g, x, y;
      logic gd;
      logic [2:0] o;
      int w;

      #23 rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("rst_in_ready", irdy[k], 1'b1);
         chk("rst_out_valid", ovld[k], 1'b0);
         chk("rst_out", outv[k], 32'h0);
         chk("rst_div_zero", dzv[k], 1'b0);
      end

      lit("mul_1234x10", 3'd0, 32'h1234, 32'h0010, 32'h2340, 1'b0);
      lit("mulhu_1234x10", 3'd1, 32'h1234, 32'h0010, 32'h0001, 1'b0);
      lit("mulhu_ffff", 3'd1, 32'hFFFF, 32'hFFFF, 32'hFFFE, 1'b0);
      lit("mulh_ffff", 3'd2, 32'hFFFF, 32'hFFFF, 32'h0000, 1'b0);
      lit("mul_ffff", 3'd0, 32'hFFFF, 32'hFFFF, 32'h0001, 1'b0);
      lit("divu_1000_7", 3'd3, 32'd1000, 32'd7, 32'h008E, 1'b0);
      lit("remu_1000_7", 3'd4, 32'd1000, 32'd7, 32'h0006, 1'b0);
      lit("div_m7_2", 3'd5, 32'hFFF9, 32'h0002, 32'hFFFD, 1'b0);
      lit("rem_m7_2", 3'd6, 32'hFFF9, 32'h0002, 32'hFFFF, 1'b0);
      lit("div_ovf", 3'd5, 32'h8000, 32'hFFFF, 32'h8000, 1'b0);
      lit("rem_ovf", 3'd6, 32'h8000, 32'hFFFF, 32'h0000, 1'b0);
      lit("divu_zero", 3'd3, 32'h1234, 32'h0000, 32'hFFFF, 1'b1);
      lit("rem_zero", 3'd6, 32'h8001, 32'h0000, 32'h8001, 1'b1);
      lit("op7", 3'd7, 32'h1234, 32'h5678, 32'h0000, 1'b0);

      // backpressure then back-to-back acceptance in the cycle after handoff
      run_op(1, 3'd4, 32'd1000, 32'd7, 5, g, gd);
      chk("bp_result", g, 32'h0006);
      run_op(1, 3'd0, 32'd9, 32'd11, 0, g, gd);
      chk("b2b_result", g, 32'd99);

      // flush in cycle 5 of a DIVU
      iv[1] = 1'b1; opv[1] = 3'd3; av[1] = 32'd1000; bv[1] = 32'd7;
      @(negedge clk);
      iv[1] = 1'b0;
      repeat (4) @(negedge clk);
      fl[1] = 1'b1;
      @(negedge clk);
      fl[1] = 1'b0;
      chk("flush_in_ready", irdy[1], 1'b1);
      chk("flush_out_valid", ovld[1], 1'b0);
      repeat (25) @(negedge clk);

      // flush together with in_valid in IDLE
      iv[1] = 1'b1; opv[1] = 3'd0; av[1] = 32'd3; bv[1] = 32'd5; fl[1] = 1'b1;
      @(negedge clk);
      iv[1] = 1'b0; fl[1] = 1'b0;
      chk("flush_idle_not_accepted", irdy[1], 1'b1);
      repeat (20) @(negedge clk);

      // reset mid-RUN after a result that left out/div_zero non-zero
      lit("pre_rst_divu_zero", 3'd3, 32'h0042, 32'h0000, 32'hFFFF, 1'b1);
      iv[1] = 1'b1; opv[1] = 3'd1; av[1] = 32'h7777; bv[1] = 32'h3333;
      @(negedge clk);
      iv[1] = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", irdy[1], 1'b1);
      chk("midrst_out_valid", ovld[1], 1'b0);
      chk("midrst_out", outv[1], 32'h0);
      chk("midrst_div_zero", dzv[1], 1'b0);
      #2 rst_n = 1'b1;
      @(negedge clk);
      repeat (20) @(negedge clk);
      lit("post_rst_mul_3x5", 3'd0, 32'd3, 32'd5, 32'h000F, 1'b0);

      // randomised sweep across widths
      for (int k = 0; k < 3; k++) begin
         w = wof(k);
         for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 9))
               0: y = 32'h0;
               1: y = 32'hFFFF_FFFF;
               2: x = 32'd1 << (w - 1);
               3: begin x = 32'd1 << (w - 1); y = 32'hFFFF_FFFF; end
               4: y = $urandom_range(1, 5);
               default: ;
            endcase
            run_op(k, o, x, y, $urandom_range(0, 2), g, gd);
         end
      end

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
